// File: rtl/mipi_csi_tx_pkg.sv
// Shared types and constants for the CSI-2 TX lane distributor.
// Provides the FSM state enum, the sync byte, the skew default and a skew clamp.
package mipi_csi_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [7:0] SYNC_BYTE        = 8'hB8;
    localparam int         MAX_SKEW_DEFAULT = 7;

    // Clamp a 3-bit skew request to the configured maximum.
    function automatic logic [2:0] sat_skew(input logic [2:0] s, input int max_skew);
        if (int'(s) > max_skew) begin
            return 3'(max_skew);
        end
        return s;
    endfunction

endpackage

// File: rtl/mipi_csi_tx_lane_distributor_if.sv
// Single-lane word stream between the distributor and a lane delay line.
// Ports: word (lane word), valid (lane valid); master drives, slave observes.
interface mipi_csi_tx_lane_distributor_if #(
    parameter int W = 16
);
    logic [W-1:0] word;
    logic         valid;

    modport master (output word, output valid);
    modport slave  (input  word, input  valid);
endinterface

// File: rtl/mipi_csi_tx_lane_delay.sv
// Per-lane programmable delay: one capture register plus a MAX_SKEW-deep chain.
// Ports: clk_i, reset_i, skew_i (latched delay), in_if (pre-skew), out_if (delayed).
module mipi_csi_tx_lane_delay
    import mipi_csi_tx_pkg::*;
#(
    parameter int MIPI_GEAR = 16,
    parameter int MAX_SKEW  = MAX_SKEW_DEFAULT
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [2:0]                            skew_i,
    mipi_csi_tx_lane_distributor_if.slave         in_if,
    mipi_csi_tx_lane_distributor_if.master        out_if
);

    localparam int DEPTH = MAX_SKEW + 1;

    logic [MIPI_GEAR-1:0] word_q [DEPTH];
    logic [MIPI_GEAR-1:0] word_d [DEPTH];
    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     valid_d;
    logic [2:0]           sel;

    // Tap k holds the word created k+1 cycles ago.
    always_comb begin
        word_d[0]  = in_if.word;
        valid_d[0] = in_if.valid;
        for (int k = 1; k < DEPTH; k++) begin
            word_d[k]  = word_q[k-1];
            valid_d[k] = valid_q[k-1];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                word_q[k] <= '0;
            end
            valid_q <= '0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign sel          = sat_skew(skew_i, MAX_SKEW);
    assign out_if.word  = word_q[sel];
    assign out_if.valid = valid_q[sel];

endmodule

// File: rtl/mipi_csi_tx_lane_distributor.sv
// CSI-2 TX lane distributor: splits packet beats across lanes, prefixes a sync word,
// applies per-lane skew. Ports: clk_i/reset_i, data_i/valid_i/last_i/last_lanes_i/ready_o
// beat input, skew_i, lane_bytes_o/lane_valid_o lane outputs, busy_o, underrun_o.
module mipi_csi_tx_lane_distributor
    import mipi_csi_tx_pkg::*;
#(
    parameter int MIPI_GEAR  = 16,
    parameter int MIPI_LANES = 4,
    parameter int MAX_SKEW   = MAX_SKEW_DEFAULT
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [MIPI_GEAR*MIPI_LANES-1:0] data_i,
    input  logic                            valid_i,
    input  logic                            last_i,
    input  logic [2:0]                      last_lanes_i,
    output logic                            ready_o,
    input  logic [3*MIPI_LANES-1:0]         skew_i,
    output logic [MIPI_GEAR*MIPI_LANES-1:0] lane_bytes_o,
    output logic [MIPI_LANES-1:0]           lane_valid_o,
    output logic                            busy_o,
    output logic                            underrun_o
);

    localparam int CNT_W = $clog2(MAX_SKEW + 1) + 1;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3*MIPI_LANES-1:0] skew_q, skew_d;

    logic [MIPI_GEAR-1:0]    pre_word [MIPI_LANES];
    logic [MIPI_LANES-1:0]   pre_valid;
    logic [2:0]              last_n;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            skew_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            skew_q  <= skew_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        skew_d  = skew_q;
        unique case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    state_d = ST_SYNC;
                    // Skew is frozen here so mid-packet changes cannot tear lanes.
                    for (int i = 0; i < MIPI_LANES; i++) begin
                        skew_d[i*3 +: 3] = sat_skew(skew_i[i*3 +: 3], MAX_SKEW);
                    end
                end
            end
            ST_SYNC: state_d = ST_DATA;
            ST_DATA: begin
                if (valid_i && last_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                // Hold long enough for the slowest lane to flush its final word.
                if (cnt_q == CNT_W'(MAX_SKEW)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_o    = (state_q == ST_DATA);
        busy_o     = (state_q != ST_IDLE);
        underrun_o = (state_q == ST_DATA) && !valid_i;

        if (last_lanes_i == 3'd0 || int'(last_lanes_i) > MIPI_LANES) begin
            last_n = 3'(MIPI_LANES);
        end else begin
            last_n = last_lanes_i;
        end

        pre_valid = '0;
        for (int i = 0; i < MIPI_LANES; i++) begin
            pre_word[i] = '0;
        end

        if (state_q == ST_SYNC) begin
            for (int i = 0; i < MIPI_LANES; i++) begin
                pre_word[i]  = MIPI_GEAR'(SYNC_BYTE);
                pre_valid[i] = 1'b1;
            end
        end else if (state_q == ST_DATA && valid_i) begin
            // Unused lanes of a short final beat stay zero as well as invalid.
            for (int i = 0; i < MIPI_LANES; i++) begin
                if (!last_i || 3'(i) < last_n) begin
                    pre_word[i]  = data_i[i*MIPI_GEAR +: MIPI_GEAR];
                    pre_valid[i] = 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < MIPI_LANES; g++) begin : g_lane
        mipi_csi_tx_lane_distributor_if #(.W(MIPI_GEAR)) pre_if ();
        mipi_csi_tx_lane_distributor_if #(.W(MIPI_GEAR)) post_if ();

        assign pre_if.word  = pre_word[g];
        assign pre_if.valid = pre_valid[g];

        mipi_csi_tx_lane_delay #(
            .MIPI_GEAR (MIPI_GEAR),
            .MAX_SKEW  (MAX_SKEW)
        ) u_delay (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .skew_i  (skew_q[g*3 +: 3]),
            .in_if   (pre_if.slave),
            .out_if  (post_if.master)
        );

        assign lane_bytes_o[g*MIPI_GEAR +: MIPI_GEAR] = post_if.word;
        assign lane_valid_o[g]                        = post_if.valid;
    end

endmodule

// File: tb/tb_mipi_csi_tx_lane_distributor.sv
// Directed bench for the lane distributor with hand-computed lane vectors.
// Drives beats one cycle at a time and checks outputs mid-cycle.
module tb_mipi_csi_tx_lane_distributor;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] data_i;
    logic        valid_i;
    logic        last_i;
    logic [2:0]  last_lanes_i;
    logic        ready_o;
    logic [11:0] skew_i;
    logic [63:0] lane_bytes_o;
    logic [3:0]  lane_valid_o;
    logic        busy_o;
    logic        underrun_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    mipi_csi_tx_lane_distributor #(
        .MIPI_GEAR  (16),
        .MIPI_LANES (4),
        .MAX_SKEW   (7)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .last_i       (last_i),
        .last_lanes_i (last_lanes_i),
        .ready_o      (ready_o),
        .skew_i       (skew_i),
        .lane_bytes_o (lane_bytes_o),
        .lane_valid_o (lane_valid_o),
        .busy_o       (busy_o),
        .underrun_o   (underrun_o)
    );

    mipi_csi_tx_lane_distributor_if #(.W(16)) mon_if ();
    assign mon_if.word  = lane_bytes_o[15:0];
    assign mon_if.valid = lane_valid_o[0];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        valid_i      = 1'b0;
        last_i       = 1'b0;
        last_lanes_i = 3'd4;
        data_i       = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 40) begin
            tick();
            n++;
        end
        chk(tag, busy_o, 0);
    endtask

    initial begin
        reset_i = 1'b1;
        skew_i  = '0;
        idle_in();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_bytes", lane_bytes_o, 0);
        chk("rst_ctl", {lane_valid_o, ready_o, busy_o, underrun_o}, 0);
        reset_i = 1'b0;
        tick();

        // Basic packet, all skews zero
        valid_i = 1'b1;
        data_i  = 64'h1111_1111_1111_1111;
        #1;
        chk("t1_idle_rb", {ready_o, busy_o}, 2'b00);
        tick();
        #1;
        chk("t1_sync_rb", {ready_o, busy_o}, 2'b01);
        chk("t1_sync_out", lane_valid_o, 0);
        tick();
        #1;
        chk("t1_ready", ready_o, 1);
        chk("t1_syncw", lane_bytes_o, 64'h00B8_00B8_00B8_00B8);
        chk("t1_syncv", lane_valid_o, 4'hF);
        tick();
        data_i = 64'h2222_2222_2222_2222;
        #1;
        chk("t1_b1", {lane_valid_o, lane_bytes_o}, {4'hF, 64'h1111_1111_1111_1111});
        tick();
        data_i       = 64'h3333_3333_3333_3333;
        last_i       = 1'b1;
        last_lanes_i = 3'd4;
        #1;
        chk("t1_b2", {lane_valid_o, lane_bytes_o}, {4'hF, 64'h2222_2222_2222_2222});
        tick();
        idle_in();
        #1;
        chk("t1_b3", {lane_valid_o, lane_bytes_o}, {4'hF, 64'h3333_3333_3333_3333});
        chk("t1_drain_busy", busy_o, 1);
        repeat (7) tick();
        #1;
        chk("t1_drain8", {busy_o, lane_valid_o}, {1'b1, 4'h0});
        tick();
        #1;
        chk("t1_idle", busy_o, 0);

        // Skew 0,1,2,3 with a skew change mid-packet
        skew_i  = {3'd3, 3'd2, 3'd1, 3'd0};
        valid_i = 1'b1;
        data_i  = 64'h1003_1002_1001_1000;
        tick();
        #1;
        chk("t2_sync_out", lane_valid_o, 0);
        tick();
        skew_i = '0;
        #1;
        chk("t2_c2", {lane_valid_o, lane_bytes_o}, {4'b0001, 64'h0000_0000_0000_00B8});
        tick();
        data_i = 64'h2003_2002_2001_2000;
        last_i = 1'b1;
        #1;
        chk("t2_c3", {lane_valid_o, lane_bytes_o}, {4'b0011, 64'h0000_0000_00B8_1000});
        tick();
        idle_in();
        #1;
        chk("t2_c4", {lane_valid_o, lane_bytes_o}, {4'b0111, 64'h0000_00B8_1001_2000});
        tick();
        valid_i = 1'b1;
        #1;
        chk("t2_c5", {lane_valid_o, lane_bytes_o}, {4'b1110, 64'h00B8_1002_2001_0000});
        chk("t2_drain_ctl", {ready_o, busy_o, underrun_o}, 3'b010);
        valid_i = 1'b0;
        tick();
        #1;
        chk("t2_c6", {lane_valid_o, lane_bytes_o}, {4'b1100, 64'h1003_2002_0000_0000});
        tick();
        #1;
        chk("t2_c7", {lane_valid_o, lane_bytes_o}, {4'b1000, 64'h2003_0000_0000_0000});
        tick();
        #1;
        chk("t2_c8", {lane_valid_o, lane_bytes_o}, {4'b0000, 64'h0});
        wait_idle("t2_drain_done");

        // Short final beat; new skew (zero) takes effect
        valid_i = 1'b1;
        data_i  = 64'h5555_6666_7777_8888;
        tick();
        tick();
        #1;
        chk("t3_sync_aligned", {lane_valid_o, lane_bytes_o}, {4'hF, 64'h00B8_00B8_00B8_00B8});
        tick();
        data_i       = 64'h4444_3333_2222_1111;
        last_i       = 1'b1;
        last_lanes_i = 3'd2;
        #1;
        chk("t3_b1", lane_bytes_o, 64'h5555_6666_7777_8888);
        tick();
        idle_in();
        #1;
        chk("t3_short", {lane_valid_o, lane_bytes_o}, {4'b0011, 64'h0000_0000_2222_1111});
        wait_idle("t3_drain_done");

        // DATA bubble, then final beat with last_lanes=0
        valid_i = 1'b1;
        data_i  = 64'h0123_4567_89AB_CDEF;
        tick();
        tick();
        tick();
        valid_i = 1'b0;
        #1;
        chk("t4_bub1", {underrun_o, ready_o, busy_o}, 3'b111);
        chk("t4_g1", lane_bytes_o, 64'h0123_4567_89AB_CDEF);
        tick();
        #1;
        chk("t4_bub2", {underrun_o, ready_o, busy_o}, 3'b111);
        chk("t4_bub2_v", lane_valid_o, 0);
        tick();
        valid_i      = 1'b1;
        data_i       = 64'hFEDC_BA98_7654_3210;
        last_i       = 1'b1;
        last_lanes_i = 3'd0;
        #1;
        chk("t4_resume", {underrun_o, ready_o}, 2'b01);
        chk("t4_bub_out", lane_valid_o, 0);
        tick();
        idle_in();
        #1;
        chk("t4_g2", {lane_valid_o, lane_bytes_o}, {4'hF, 64'hFEDC_BA98_7654_3210});
        chk("t4_drain_ctl", {ready_o, busy_o, underrun_o}, 3'b010);
        chk("t4_mon", {mon_if.valid, mon_if.word}, {1'b1, 16'h3210});
        wait_idle("t4_drain_done");

        // Reset during beat 2 of 4
        valid_i = 1'b1;
        data_i  = 64'h1111_1111_1111_1111;
        tick();
        tick();
        tick();
        data_i = 64'h2222_2222_2222_2222;
        #1;
        chk("t5_pre", lane_valid_o, 4'hF);
        reset_i = 1'b1;
        #1;
        chk("t5_rst_bytes", lane_bytes_o, 0);
        chk("t5_rst_ctl", {lane_valid_o, ready_o, busy_o, underrun_o}, 0);
        tick();
        reset_i = 1'b0;
        idle_in();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_post", {lane_valid_o, ready_o, busy_o, underrun_o, lane_bytes_o}, 0);
            tick();
        end
        valid_i = 1'b1;
        data_i  = 64'h9999_AAAA_BBBB_CCCC;
        #1;
        chk("t5_idle_rb", {ready_o, busy_o}, 2'b00);
        tick();
        last_i = 1'b1;
        #1;
        chk("t5_sync", {busy_o, lane_valid_o}, {1'b1, 4'h0});
        tick();
        #1;
        chk("t5_syncw", {lane_valid_o, lane_bytes_o}, {4'hF, 64'h00B8_00B8_00B8_00B8});
        tick();
        idle_in();
        #1;
        chk("t5_beat", {lane_valid_o, lane_bytes_o}, {4'hF, 64'h9999_AAAA_BBBB_CCCC});
        wait_idle("t5_drain_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
